riscv_muldiv: RTL and testbench
===============================

Name: riscv_muldiv

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M operation set.
- Sits beside the single-cycle ALU in the execute stage and uses the same operand A/B selection.
- Accepts one operation at a time over a valid/ready handshake.
- Produces a WIDTH-bit result after a bounded number of cycles, with a fast path for divide-by-zero and signed overflow.

Parameters:
- WIDTH, 32, operand and result width in bits; must be even and at least 8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept a request.
- op_i  in  3  md_op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- op_a_i  in  WIDTH  rs1 value.
- op_b_i  in  WIDTH  rs2 value.
- abort_i  in  1  pipeline flush; kills any in-flight operation.
- valid_o  out  1  result available.
- ready_i  in  1  consumer accepts result.
- result_o  out  WIDTH  result.

Behaviour:
- Reset values: ready_o=1, valid_o=0, result_o=0, FSM in IDLE, counter=0, all datapath registers 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&ready_o&!abort_i, latch op_i plus operand magnitudes: abs for signed operands, raw bits for unsigned.
  - Record the result sign: MULH = sign(a)^sign(b); MULHSU = sign(a); DIV = sign(a)^sign(b); REM = sign(a).
  - Go to CALC with counter=WIDTH.
  - Exception: a special-case division (below) goes directly to DONE.
- CALC:
  - ready_o=0.
  - One iteration per cycle; counter decrements each cycle.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - When counter reaches 1, the next state is DONE.
  - On entering DONE, apply the sign correction (two's-complement negate) and register the selected slice into result_o: low WIDTH bits for MUL, high WIDTH bits for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
- DONE:
  - valid_o=1; result_o held stable while valid_o&!ready_i.
  - On ready_i, go to IDLE; valid_o drops the next cycle.
  - ready_o=0 in DONE, so there is no back-to-back overlap.
- Latency: valid_o asserts WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
- Fast path: valid_o asserts 1 cycle after the accepting edge for these cases:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = op_a_i unchanged.
  - Signed overflow (op_a_i = most negative, op_b_i = all ones, DIV/REM only): quotient = op_a_i, remainder = 0.
- MUL sign handling: the low half is sign-agnostic. MUL uses the unsigned magnitude path with the sign flag cleared.
- MULHU/DIVU/REMU: no sign correction.
- abort_i:
  - Highest priority in every state.
  - The next state is IDLE, with valid_o=0 the next cycle.
  - A request presented in the same cycle as abort_i is not accepted.
- Reset mid-operation: everything returns to reset values immediately, asynchronously.
- result_o may change only when entering DONE; it is not cleared on leaving DONE.

Decomposition:
- Add to the shared package:
  - typedef md_op (logic [2:0]): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - typedef md_state (IDLE, CALC, DONE).
  - Add opcode-level constant OPCODE_OP funct7 = 7'h01 for M-extension decode.
- One sub-module is natural: riscv_muldiv_negate, a parametrised conditional two's-complement negate. It is instantiated for operand magnitude and for result sign correction.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> valid_o after 33 cycles, result_o = 0xFFFFFFEB.
- MULH / MULHSU / MULHU with 0x80000000 x 0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both in 1 cycle; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, in 1 cycle.
- Backpressure and abort:
  - Hold ready_i=0 for 5 cycles in DONE -> result_o and valid_o stable, ready_o=0.
  - Assert abort_i at CALC cycle 10 -> valid_o never rises, ready_o=1 the next cycle.
  - A new request then completes correctly.
- Drop rst_ni mid-CALC -> outputs return to reset values immediately; after release, the first operation is correct.

Source files
------------

// File: rtl/riscv_muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package riscv_muldiv_pkg;

    localparam int unsigned MD_OP_W    = 3;
    localparam int unsigned MD_STATE_W = 2;

    // funct7 value that selects the M extension within the OP major opcode
    localparam logic [6:0] OPCODE_OP_FUNCT7_M = 7'h01;

    typedef enum logic [MD_OP_W-1:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op;

    typedef enum logic [MD_STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state;

endpackage

// File: rtl/riscv_muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module riscv_muldiv_negate
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_c
);

    assign y_c = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide,
// one-cycle fast path for divide-by-zero and signed overflow.
module riscv_muldiv
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             abort_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned AW = 2 * WIDTH;

    md_state              state_q, state_d;
    md_op                 op_q, op_d;
    logic                 sign_q, sign_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     result_q, result_d;

    md_op                 op_in;
    logic                 signed_a, signed_b, sign_in;
    logic                 div_zero, div_ovf, fast;
    logic [WIDTH-1:0]     mag_a, mag_b, fast_res;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [AW-1:0]        mul_next, div_next, acc_nxt;
    logic [AW-1:0]        pre_fix, fixed;
    logic [WIDTH-1:0]     res_slice;

    assign op_in    = md_op'(op_i);
    assign signed_a = (op_in == MULH) || (op_in == MULHSU) || (op_in == DIV) || (op_in == REM);
    assign signed_b = (op_in == MULH) || (op_in == DIV) || (op_in == REM);

    riscv_muldiv_negate #(.W(WIDTH)) u_neg_a (
        .neg_i (signed_a & op_a_i[WIDTH-1]),
        .a_i   (op_a_i),
        .y_c   (mag_a)
    );

    riscv_muldiv_negate #(.W(WIDTH)) u_neg_b (
        .neg_i (signed_b & op_b_i[WIDTH-1]),
        .a_i   (op_b_i),
        .y_c   (mag_b)
    );

    // Request decode: result sign and the special-case division outcomes
    always_comb begin
        sign_in = 1'b0;
        case (op_in)
            MULH, DIV:   sign_in = op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
            MULHSU, REM: sign_in = op_a_i[WIDTH-1];
            default:     sign_in = 1'b0;
        endcase
        div_zero = (op_b_i == '0);
        div_ovf  = ((op_in == DIV) || (op_in == REM)) &&
                   (op_a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b_i == '1);
        fast     = op_in[2] && (div_zero || div_ovf);
        if (div_zero) fast_res = op_in[1] ? op_a_i : '1;
        else          fast_res = op_in[1] ? '0 : op_a_i;
    end

    // One iteration: acc = {partial product / remainder, multiplier / dividend-quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = acc_q[AW-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, b_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
        acc_nxt   = op_q[2] ? div_next : mul_next;
        pre_fix   = op_q[2] ? {WIDTH'(0), (op_q[1] ? acc_nxt[AW-1:WIDTH] : acc_nxt[WIDTH-1:0])}
                            : acc_nxt;
    end

    // Full-width negate so the high product half picks up the borrow from the low half
    riscv_muldiv_negate #(.W(AW)) u_neg_res (
        .neg_i (sign_q),
        .a_i   (pre_fix),
        .y_c   (fixed)
    );

    assign res_slice = (!op_q[2] && (op_q != MUL)) ? fixed[AW-1:WIDTH] : fixed[WIDTH-1:0];

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (valid_i && ready_q && !abort_i) begin
                    op_d   = op_in;
                    sign_d = sign_in;
                    b_d    = mag_b;
                    acc_d  = {WIDTH'(0), mag_a};
                    if (fast) begin
                        state_d  = DONE;
                        result_d = fast_res;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNT_W'(WIDTH);
                    end
                end
            end
            CALC: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    result_d = res_slice;
                end
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= MUL;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Scoreboard bench for riscv_muldiv: directed RV32M vectors, fast paths, backpressure, abort, reset.
module tb_riscv_muldiv;
    import riscv_muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic         clk_i;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    logic [2:0]   op_i;
    logic [W-1:0] op_a_i;
    logic [W-1:0] op_b_i;
    logic         abort_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] result_o;

    riscv_muldiv #(.WIDTH(W)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .abort_i  (abort_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o)
    );

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    logic prev_valid = 1'b0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endfunction

    // Monitor: latency on valid_o rise, result on output handshake
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni) begin
            if (valid_i && ready_o && !abort_i) acc_cyc = cyc + 1;
            if (valid_o && !prev_valid) begin
                check("exp_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check({"lat_", exp_q[0].name}, 32'(cyc - acc_cyc + 1), 32'(exp_q[0].lat));
            end
            if (valid_o && ready_i && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({"res_", e.name}, result_o, e.res);
            end
            prev_valid = valid_o;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic issue(input md_op op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input int lat, input string name, input bit track);
        exp_t e;
        int t = 0;
        while (!ready_o && t < 100) begin
            @(posedge clk_i); #1;
            t++;
        end
        check({"ready_", name}, 32'(ready_o), 32'd1);
        if (track) begin
            e.res = r; e.lat = lat; e.name = name;
            exp_q.push_back(e);
        end
        valid_i = 1'b1;
        op_i    = op;
        op_a_i  = a;
        op_b_i  = b;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk_i); #1;
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run(input md_op op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input int lat, input string name);
        issue(op, a, b, r, lat, name, 1'b1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_ni = 1'b0; valid_i = 1'b0; op_i = 3'd0; op_a_i = '0; op_b_i = '0;
        abort_i = 1'b0; ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Multiply family
        run(MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7_m3");
        run(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul_m1_m1");
        run(MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh");
        run(MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "mulhsu");
        run(MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33, "mulhu");

        // Divide family
        run(DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "div_m7_2");
        run(REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "rem_m7_2");
        run(DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
        run(REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, "rem_7_m2");
        run(DIVU, 32'd100,       32'd7,         32'd14,        33, "divu_100_7");
        run(REMU, 32'd100,       32'd7,         32'd2,         33, "remu_100_7");
        run(DIVU, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33, "divu_max_1");
        run(REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, "remu_big_div");

        // Fast paths
        run(DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
        run(REM,  32'd5,         32'd0,         32'd5,         1, "rem_by0");
        run(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");

        // Backpressure: result held while the consumer stalls
        ready_i = 1'b0;
        issue(DIVU, 32'd100, 32'd7, 32'd14, 33, "bp_divu", 1'b1);
        for (int i = 0; i < 100 && !valid_o; i++) @(negedge clk_i);
        check("bp_wait", 32'(valid_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_valid", 32'(valid_o), 32'd1);
            check("bp_result", result_o, 32'd14);
            check("bp_ready", 32'(ready_o), 32'd0);
        end
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("bp_valid_drop", 32'(valid_o), 32'd0);
        check("bp_ready_back", 32'(ready_o), 32'd1);
        drain();

        // Abort in the tenth CALC cycle
        issue(MUL, 32'd5, 32'd6, 32'd30, 33, "abort_mul", 1'b0);
        repeat (9) @(posedge clk_i);
        #1;
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        @(negedge clk_i);
        check("abort_ready", 32'(ready_o), 32'd1);
        check("abort_valid", 32'(valid_o), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);

        // Request coincident with abort is dropped
        @(posedge clk_i); #1;
        valid_i = 1'b1; abort_i = 1'b1; op_i = DIVU; op_a_i = 32'd5; op_b_i = 32'd0;
        @(posedge clk_i); #1;
        valid_i = 1'b0; abort_i = 1'b0;
        @(negedge clk_i);
        check("abort_req_valid", 32'(valid_o), 32'd0);
        check("abort_req_ready", 32'(ready_o), 32'd1);

        run(MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33, "post_abort");

        // Asynchronous reset mid-CALC
        issue(DIV, 32'd100, 32'd7, 32'd14, 33, "rst_div", 1'b0);
        repeat (5) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_ready", 32'(ready_o), 32'd1);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_result", result_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run(REM, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "post_rst");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
